// File: rtl/uart_tx_scheduler_if.sv
// Byte-request bus between on-chip sources and uart_tx_scheduler.
// req_lock exists only when UART_TX_LOCK_EN is defined.
interface uart_tx_scheduler_if #(
    parameter int NREQ = 2
) ();
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ack;
`ifdef UART_TX_LOCK_EN
    logic [NREQ-1:0]   req_lock;

    modport master (output req_valid, req_data, req_lock, input req_ack);
    modport slave  (input req_valid, req_data, req_lock, output req_ack);
`else
    modport master (output req_valid, req_data, input req_ack);
    modport slave  (input req_valid, req_data, output req_ack);
`endif
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one 8N1 UART transmit line between NREQ byte sources.
// Optional UART_TX_LOCK_EN lets the current owner keep the line for multi-byte messages.
module uart_tx_scheduler #(
    parameter int NREQ      = 2,
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_scheduler_if.slave req_bus,
    output logic               uart_tx,
    output logic               busy,
    output logic [IDW-1:0]     grant_id
);
    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(DIV);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [IDW-1:0]  ptr_q, ptr_d;

    logic            lock_hit;
    logic            found;
    logic [IDW-1:0]  win;
    logic [IDW-1:0]  cand;
    logic            bit_end;

`ifdef UART_TX_LOCK_EN
    assign lock_hit = req_bus.req_lock[grant_q] & req_bus.req_valid[grant_q];
`else
    assign lock_hit = 1'b0;
`endif

    // ptr_q is the search start (last grant + 1), kept apart from grant_id so
    // that requester 0 gets first priority after reset while grant_id reads 0.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IDW'((32'(ptr_q) + i) % NREQ);
            if (!found && req_bus.req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        if (lock_hit) begin
            found = 1'b1;
            win   = grant_q;
        end
    end

    assign bit_end = (cnt_q == CW'(DIV - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        ack_d   = '0;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (found) begin
                    sh_d       = req_bus.req_data[8*win +: 8];
                    grant_d    = win;
                    ptr_d      = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
                    ack_d[win] = 1'b1;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    tx_d       = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = sh_q[0];
                    sh_d    = {1'b0, sh_q[7:1]};
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        tx_d  = sh_q[0];
                        sh_d  = {1'b0, sh_q[7:1]};
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ack_q   <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign req_bus.req_ack = ack_q;
    assign uart_tx         = tx_q;
    assign busy            = busy_q;
    assign grant_id        = grant_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: requester queues feed the bus, a line
// decoder pops the expected-byte scoreboard; lock expectations follow UART_TX_LOCK_EN.
module tb_uart_tx_scheduler;
    localparam int NREQ      = 2;
    localparam int CLK_FREQ  = 921600;
    localparam int BAUD_RATE = 115200;
    localparam int DIV       = CLK_FREQ / BAUD_RATE;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_tx;
    logic       busy;
    logic [0:0] grant_id;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    int unsigned start_times[$];
    int unsigned grant_log[$];

    uart_tx_scheduler_if #(.NREQ(NREQ)) bus ();

    uart_tx_scheduler #(
        .NREQ(NREQ),
        .CLK_FREQ(CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_bus(bus),
        .uart_tx(uart_tx),
        .busy(busy),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    initial forever @(posedge clk) cyc++;

    // Requesters: present the next queued byte when idle or on the ack cycle.
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        forever @(negedge clk) begin
            if (bus.req_ack[0] || !bus.req_valid[0]) begin
                if (q0.size() != 0) begin
                    bus.req_data[7:0] = q0.pop_front();
                    bus.req_valid[0]  = 1'b1;
                end else begin
                    bus.req_valid[0] = 1'b0;
                end
            end
            if (bus.req_ack[1] || !bus.req_valid[1]) begin
                if (q1.size() != 0) begin
                    bus.req_data[15:8] = q1.pop_front();
                    bus.req_valid[1]   = 1'b1;
                end else begin
                    bus.req_valid[1] = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [1:0] prev_ack;
        prev_ack = '0;
        forever @(negedge clk) begin
            if (rst_n && (bus.req_ack != 0)) begin
                grant_log.push_back(32'(grant_id));
                chk("ack_onehot", 32'($onehot(bus.req_ack)), 1);
                chk("ack_one_cycle", 32'(bus.req_ack & prev_ack), 0);
                chk("ack_tx_start_low", 32'(uart_tx), 0);
                chk("ack_busy_high", 32'(busy), 1);
                chk("ack_matches_grant", 32'(bus.req_ack[grant_id]), 1);
            end
            prev_ack = bus.req_ack;
        end
    end

    // Line decoder: samples mid-bit, aborts on reset.
    initial begin
        bit          dbusy;
        logic        ptx;
        int unsigned dcnt;
        logic [7:0]  dbyte;
        dbusy = 1'b0;
        ptx   = 1'b1;
        dcnt  = 0;
        dbyte = '0;
        forever @(negedge clk) begin
            if (!rst_n) begin
                dbusy = 1'b0;
                ptx   = 1'b1;
            end else begin
                if (!dbusy && ptx && !uart_tx) begin
                    dbusy = 1'b1;
                    dcnt  = 0;
                    start_times.push_back(cyc);
                end
                if (dbusy) begin
                    if (dcnt % DIV == DIV / 2) begin
                        if (dcnt / DIV == 0) begin
                            chk("rx_start_bit", 32'(uart_tx), 0);
                        end else if (dcnt / DIV <= 8) begin
                            dbyte[dcnt / DIV - 1] = uart_tx;
                        end else begin
                            chk("rx_stop_bit", 32'(uart_tx), 1);
                            chk("rx_frame_expected", 32'(exp_q.size() > 0), 1);
                            if (exp_q.size() > 0) chk("rx_byte", 32'(dbyte), 32'(exp_q.pop_front()));
                            dbusy = 1'b0;
                        end
                    end
                    dcnt++;
                end
                ptx = uart_tx;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int unsigned t;
        t = 0;
        while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0 || busy
                || bus.req_valid != 0) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(t < 5000), 1);
    endtask

    task automatic chk_grants(input string tag, input int unsigned g0, input int unsigned g1,
                              input int unsigned g2, input int unsigned g3, input int unsigned n);
        int unsigned exp_g[4];
        exp_g = '{g0, g1, g2, g3};
        chk({tag, "_count"}, grant_log.size(), n);
        for (int unsigned i = 0; i < n; i++)
            if (i < grant_log.size()) chk(tag, grant_log[i], exp_g[i]);
    endtask

    initial begin
        int unsigned acks;
        int unsigned busy_cyc;
        int unsigned t;
`ifdef UART_TX_LOCK_EN
        bus.req_lock = '0;
`endif
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_uart_tx", 32'(uart_tx), 1);
        chk("reset_req_ack", 32'(bus.req_ack), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_grant_id", 32'(grant_id), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte 0x55 from requester 0
        acks = 0;
        busy_cyc = 0;
        exp_q.push_back(8'h55);
        q0.push_back(8'h55);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.req_ack[0]) acks++;
            if (busy) busy_cyc++;
        end
        chk("single_ack_count", acks, 1);
        chk("single_busy_cycles", busy_cyc, 80);
        drain("single_drain");

        // Simultaneous requests from reset
        do_reset();
        start_times.delete();
        grant_log.delete();
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        q0.push_back(8'h41);
        q1.push_back(8'h42);
        drain("simul_drain");
        chk("simul_starts", start_times.size(), 2);
        if (start_times.size() >= 2)
            chk("simul_start_spacing", start_times[1] - start_times[0], 10 * DIV + 1);
        chk_grants("simul_grant", 0, 1, 0, 0, 2);

        // Continuous contention, four frames
        grant_log.delete();
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA2);
        exp_q.push_back(8'hA3);
        q0.push_back(8'hA0);
        q0.push_back(8'hA2);
        q1.push_back(8'hA1);
        q1.push_back(8'hA3);
        drain("contend_drain");
        chk_grants("contend_grant", 0, 1, 0, 1, 4);

        // Reset during DATA bit 3 of 0x52 (bit 3 is 0)
        q0.push_back(8'h52);
        t = 0;
        while (!bus.req_ack[0] && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("mid_ack_seen", 32'(bus.req_ack[0]), 1);
        repeat (34) @(negedge clk);
        chk("mid_bit3_low", 32'(uart_tx), 0);
        chk("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_uart_tx", 32'(uart_tx), 1);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ack", 32'(bus.req_ack), 0);
        rst_n = 1'b1;
        acks = 0;
        busy_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ack != 0) acks++;
            if (busy || !uart_tx) busy_cyc++;
        end
        chk("mid_no_reissue_ack", acks, 0);
        chk("mid_line_idle", busy_cyc, 0);
        grant_log.delete();
        exp_q.push_back(8'h66);
        exp_q.push_back(8'h77);
        q0.push_back(8'h66);
        q1.push_back(8'h77);
        drain("mid_after_drain");
        chk_grants("mid_after_grant", 0, 1, 0, 0, 2);

        // Lock: req0 sends 0x31..0x33 with lock high, req1 holds 0x39
        do_reset();
        grant_log.delete();
`ifdef UART_TX_LOCK_EN
        bus.req_lock = 2'b01;
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h32);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h39);
`else
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h39);
        exp_q.push_back(8'h32);
        exp_q.push_back(8'h33);
`endif
        q0.push_back(8'h31);
        q0.push_back(8'h32);
        q0.push_back(8'h33);
        q1.push_back(8'h39);
        drain("lock_drain");
`ifdef UART_TX_LOCK_EN
        chk_grants("lock_grant", 0, 0, 0, 1, 4);
        bus.req_lock = '0;
`else
        chk_grants("lock_grant", 0, 1, 0, 0, 4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

- Shares one UART transmit line between `NREQ` byte requesters, such as the CPU console port and a debug/trace port.
- Round-robin arbitration selects one requester per frame; the block contains its own baud counter and 8N1 frame sequencer.
- Sits between on-chip byte sources and the board-level `uart_tx` pin.
- Its output is the stream the testbench UART decoder consumes.

## Interface
- `NREQ`, 2 — number of requesters, 2..4.
- `CLK_FREQ`, 50000000 — clock frequency in Hz.
- `BAUD_RATE`, 115200 — line rate in bit/s. `DIV = CLK_FREQ/BAUD_RATE` (integer truncation); `DIV` must be >= 2.
- `clk` in 1 — single clock; all logic on its rising edge.
- `rst_n` in 1 — synchronous, active-low reset.
- `req_valid` in NREQ — bit i: requester i has a byte pending.
- `req_data` in 8*NREQ — byte of requester i in bits [8i+7:8i].
- `req_lock` in NREQ — keep grant for the next byte (present only with `UART_TX_LOCK_EN`).
- `req_ack` out NREQ — one-cycle pulse: byte of requester i accepted.
- `uart_tx` out 1 — serial line, idle high.
- `busy` out 1 — frame in progress.
- `grant_id` out clog2(NREQ), minimum 1 bit — index of the last granted requester.

## Operation
- **Reset values** (first edge with `rst_n`=0): `uart_tx`=1, `req_ack`=0, `busy`=0, `grant_id`=0, state IDLE, round-robin pointer=0 (requester 0 has highest priority first).
- **IDLE**
  - If no `req_valid` is set, stay in IDLE.
  - Otherwise pick the winner w: the first set `req_valid` bit searching from `(grant_id+1) mod NREQ` upward with wrap. After reset the search starts at 0.
  - On that edge: latch `req_data[w]` into the shift register, `grant_id`<=w, `req_ack[w]`<=1 for exactly one cycle, `busy`<=1, go to START.
- **Requester handshake**
  - Hold `req_valid` and `req_data` stable until `req_ack` is seen.
  - On the cycle `req_ack` is high, either drop `req_valid` or present the next byte.
  - `req_valid` with no ack is never dropped by the scheduler; a requester may withdraw it before ack with no effect.
- **START**: `uart_tx`=0 for `DIV` cycles.
- **DATA**: 8 bits, LSB first, each held `DIV` cycles. A 3-bit counter runs 0..7.
- **STOP**: `uart_tx`=1 for `DIV` cycles, then go to IDLE with `busy`<=0.
- **Baud counter**: width clog2(DIV). Counts 0..DIV-1, reloads to 0 at each bit boundary, and is cleared on entry to START.
- **Simultaneous requests**: exactly one ack per frame; losers keep waiting.
- **Fairness**: with all requesters continuously valid, grants cycle 0,1,..,NREQ-1,0.
- **Reset mid-frame**: the frame is aborted, `uart_tx` returns to 1 on that edge, and no ack is reissued. The aborted byte is lost; the requester already got its ack.

## Timing
- Request to ack: `req_valid` sampled high in IDLE at edge k gives `req_ack` high during cycle k+1. The start bit also begins at edge k, so `uart_tx` is low from cycle k+1.
- Frame length is `10*DIV` cycles from start-bit edge to end of stop bit.
- After STOP the block spends exactly one cycle in IDLE before the next start bit. Back-to-back frame period is `10*DIV+1` cycles.
- `busy` is high from the ack cycle through the last stop-bit cycle.
- No combinational path from any input to any output.

## Configuration
- **Macro `UART_TX_LOCK_EN` defined**
  - The `req_lock` port exists.
  - If `req_lock[grant_id]` and `req_valid[grant_id]` are both high when arbitration runs, that requester wins again and round-robin is bypassed. This lets multi-byte messages go out atomically.
  - Lock lasts while the requester keeps lock and valid high; dropping either returns to normal round-robin at the next arbitration.
- **Macro undefined**: the port is absent and the block uses pure round-robin.

## Test plan
Unless stated otherwise, benches use CLK_FREQ=921600, BAUD_RATE=115200 (DIV=8), NREQ=2.
- **Single byte**: requester 0 sends 0x55.
  - `req_ack[0]` pulses 1 cycle.
  - `uart_tx` shows start, then 1,0,1,0,1,0,1,0, then stop, 8 cycles per bit.
  - `busy` is high 80 cycles.
  - The UART decoder reports 0x55.
- **Simultaneous requests from reset**: req0=0x41 and req1=0x42 both valid.
  - Order is 0x41 then 0x42.
  - Second start bit begins exactly 81 cycles after the first.
- **Continuous contention**: both requesters valid for 4 frames.
  - `grant_id` sequence is 0,1,0,1.
  - Acks alternate, one per frame.
- **Reset mid-frame**: `rst_n` low during the DATA state at bit 3.
  - `uart_tx`=1, `busy`=0, `req_ack`=0 after that edge.
  - Next request after release starts a clean frame with grant from requester 0.
- **Lock, `UART_TX_LOCK_EN` defined**: req0 has lock high and 3 bytes 0x31,0x32,0x33; req1 is valid with 0x39 throughout.
  - Line order is 0x31,0x32,0x33,0x39.
- **Lock, macro undefined**: same stimulus.
  - Line order is 0x31,0x39,0x32,0x33.
